// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: hides FIFO read latency behind a 2-entry valid/ready buffer with burst framing
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_r_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             idle
);
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
  logic [1:0]       occ;
  logic             inflight;
  logic [BW-1:0]    beat;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] b1;
  logic             pop;
  logic [1:0]       wp;
  // read issue keeps occ + inflight <= 2; the pop term lets a freed slot refill in the same cycle
  always_comb begin
    pop       = m_valid & m_ready;
    m_valid   = occ != 2'd0;
    m_data    = b0;
    m_last    = m_valid & (beat == LAST);
    idle      = (occ == 2'd0) & !inflight & fifo_empty;
    fifo_r_en = !rst & !fifo_empty & (((occ + {1'b0, inflight}) < 2'd2) | pop);
    wp        = occ - {1'b0, pop};
  end
  // occupancy, read-in-flight flag and beat position; reset drops any in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      inflight <= fifo_r_en;
      beat     <= pop ? ((beat == LAST) ? '0 : beat + 1'b1) : beat;
    end
  end
  // b0 is the head; a pop shifts b1 forward and the arriving word lands in the first free slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0 <= '0;
      b1 <= '0;
    end else begin
      if (pop) b0 <= b1;
      if (inflight && wp == 2'd0) b0 <= fifo_rdata;
      if (inflight && wp != 2'd0) b1 <= fifo_rdata;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed stimulus with an in-order stream model and burst position model
module tb_fifo_stream_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty, fifo_r_en, m_valid, m_ready = 1'b0, m_last, idle;
  logic [7:0] fifo_rdata = 8'h00, m_data;
  logic       fifo_empty1, fifo_r_en1, m_valid1, m_last1, idle1;
  logic       m_ready1 = 1'b1;
  logic [7:0] fifo_rdata1 = 8'h00, m_data1;
  logic [7:0] mem  [0:63];
  logic [7:0] mem1 [0:63];
  int rp = 0, wp = 0, dp = 0, nb = 0;
  int rp1 = 0, wp1 = 0, dp1 = 0;
  logic last_read = 1'b0;
  int vecs = 0, errs = 0, cyc = 0;
  int first_ren = -1, first_valid = -1;
  logic stall_prev = 1'b0, pl = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] od [$];
  logic       ol [$];
  int         oc [$];
  logic [7:0] o1 [$];
  int held;

  fifo_stream_reader #(.WIDTH(8), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .idle(idle));

  fifo_stream_reader #(.WIDTH(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_rdata(fifo_rdata1),
    .fifo_r_en(fifo_r_en1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_data(m_data1), .m_last(m_last1), .idle(idle1));

  always #5 clk = ~clk;

  assign fifo_empty  = (rp == wp);
  assign fifo_empty1 = (rp1 == wp1);

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // FIFO models: data appears the cycle after an accepted read
  always @(posedge clk) begin
    fifo_rdata  <= mem[rp[5:0]];
    rp          <= rp + int'(fifo_r_en);
    last_read   <= fifo_r_en;
    fifo_rdata1 <= mem1[rp1[5:0]];
    rp1         <= rp1 + int'(fifo_r_en1);
  end

  // compare process: stream order, burst position, hold-on-stall, read safety
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      dp = rp;
      dp1 = rp1;
      nb = 0;
      stall_prev = 1'b0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_fifo_r_en", fifo_r_en, 0);
      chk("rst_idle", idle, fifo_empty);
    end else begin
      held = rp - dp - int'(last_read);
      chk("m_valid", m_valid, held > 0);
      chk("idle", idle, (rp == dp) && fifo_empty);
      if (fifo_r_en) chk("ren_while_empty", fifo_empty, 0);
      chk("occ_bound", ((rp - dp) + int'(fifo_r_en) - int'(m_valid && m_ready)) <= 2, 1);
      if (stall_prev) begin
        chk("hold_data", m_data, pd);
        chk("hold_last", m_last, pl);
      end
      if (m_valid) chk("m_last", m_last, nb == 3);
      if (fifo_r_en && first_ren < 0) first_ren = cyc;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        chk("m_data", m_data, mem[dp[5:0]]);
        od.push_back(m_data);
        ol.push_back(m_last);
        oc.push_back(cyc);
        dp++;
        nb = (nb + 1) % 4;
      end
      stall_prev = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (fifo_r_en1) chk("ren1_while_empty", fifo_empty1, 0);
      if (m_valid1 && m_ready1) begin
        chk("m_last1", m_last1, 1);
        chk("m_data1", m_data1, mem1[dp1[5:0]]);
        o1.push_back(m_data1);
        dp1++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wp[5:0]] = v;
    wp = wp + 1;
  endtask

  task automatic clear_log;
    od.delete();
    ol.delete();
    oc.delete();
    first_ren = -1;
    first_valid = -1;
  endtask

  task automatic wait_outs(input int n);
    int k = 0;
    while (od.size() < n && k < 200) begin
      step;
      k++;
    end
    chk("outs_count", od.size(), n);
  endtask

  task automatic wait_valid;
    int k = 0;
    while (!m_valid && k < 50) begin
      step;
      k++;
    end
    chk("valid_timeout", m_valid, 1);
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  int base;

  initial begin
    // reset with FIFO empty
    step;
    step;
    chk("reset_idle", idle, 1);
    chk("reset_valid", m_valid, 0);
    rst = 1'b0;
    step;

    // 8 words, always ready: 2-cycle latency then back-to-back beats
    clear_log;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_outs(8);
    chk("latency", first_valid - first_ren, 2);
    for (int i = 0; i < od.size() && i < 8; i++) begin
      chk("t2_data", od[i], 8'h10 + 8'(i));
      chk("t2_last", ol[i], i % 4 == 3);
      chk("t2_back_to_back", oc[i] - oc[0], i);
    end
    step;
    step;
    chk("t2_idle", idle, 1);

    // stall 5 cycles after first valid: only 2 reads issued, head held
    clear_log;
    m_ready = 1'b0;
    base = rp;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_valid;
    repeat (5) step;
    chk("t3_reads", rp - base, 2);
    chk("t3_head", m_data, 8'h10);
    chk("t3_ren_off", fifo_r_en, 0);
    m_ready = 1'b1;
    wait_outs(8);
    for (int i = 0; i < od.size() && i < 8; i++) begin
      chk("t3_data", od[i], 8'h10 + 8'(i));
      chk("t3_no_gap", oc[i] - oc[0], i);
    end
    step;
    step;

    // ready toggling 1,0,1,0 with 6 words
    clear_log;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    for (int k = 0; k < 200 && od.size() < 6; k++) begin
      m_ready = ~m_ready;
      step;
    end
    chk("t4_count", od.size(), 6);
    for (int i = 0; i < od.size() && i < 6; i++) begin
      chk("t4_data", od[i], 8'h30 + 8'(i));
      chk("t4_last", ol[i], i == 3);
    end
    m_ready = 1'b1;
    step;
    step;
    pulse_rst;
    step;

    // one word, then three more after a 10+ cycle gap: burst spans the gap
    clear_log;
    push(8'h40);
    repeat (12) step;
    chk("t5_first_only", od.size(), 1);
    push(8'h41);
    push(8'h42);
    push(8'h43);
    wait_outs(4);
    for (int i = 0; i < od.size() && i < 4; i++) begin
      chk("t5_data", od[i], 8'h40 + 8'(i));
      chk("t5_last", ol[i], i == 3);
    end
    step;
    step;

    // asynchronous reset with two words buffered: both discarded
    clear_log;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    wait_valid;
    step;
    step;
    chk("t6_full_reads", rp - (wp - 4), 2);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", m_valid, 0);
    chk("t6_async_data", m_data, 0);
    chk("t6_async_ren", fifo_r_en, 0);
    step;
    rst = 1'b0;
    m_ready = 1'b1;
    wait_outs(2);
    for (int i = 0; i < od.size() && i < 2; i++) begin
      chk("t6_data", od[i], 8'h22 + 8'(i));
      chk("t6_last", ol[i], 0);
    end
    step;
    step;

    // BURST_LEN=1 instance: last on every beat
    for (int i = 0; i < 3; i++) begin
      mem1[wp1[5:0]] = 8'h50 + 8'(i);
      wp1 = wp1 + 1;
    end
    for (int k = 0; k < 50 && o1.size() < 3; k++) step;
    chk("t7_count", o1.size(), 3);
    for (int i = 0; i < o1.size() && i < 3; i++) chk("t7_data", o1[i], 8'h50 + 8'(i));
    step;
    chk("t7_idle", idle1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
